// File: rtl/mult_pkg.sv
// Shared constants and state type for the multiplier / product-accumulator datapath.
package mult_pkg;

    localparam int OPND_W = 16;
    localparam int PROD_W = 2 * OPND_W;
    localparam int ACC_W  = 40;
    localparam int CNT_W  = 9;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_e;

endpackage

// File: rtl/prod_accumulator_if.sv
// Product-in / frame-result-out handshake bundle for prod_accumulator.
interface prod_accumulator_if #(
    parameter int PROD_W = mult_pkg::PROD_W,
    parameter int ACC_W  = mult_pkg::ACC_W,
    parameter int CNT_W  = mult_pkg::CNT_W
);

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    // Producer of products and consumer of frame results.
    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

endinterface

// File: rtl/prod_accumulator_sat_counter.sv
// CNT_W-bit up-counter that sticks at all-ones; synchronous clear wins over enable.
module sat_counter #(
    parameter int CNT_W = mult_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: non-blocking for all flop updates so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/prod_accumulator.sv
// Sums a frame of unsigned products into a wide accumulator and hands back one
// registered {sum, count, sticky overflow} result per frame over valid/ready.
module prod_accumulator #(
    parameter int PROD_W = mult_pkg::PROD_W,
    parameter int ACC_W  = mult_pkg::ACC_W,
    parameter int CNT_W  = mult_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    prod_accumulator_if.slave  bus
);

    import mult_pkg::*;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum_ext;
    logic             cnt_clr;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        // One extra bit captures the carry out of the accumulator MSB.
        sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_prod};

        if (clr) begin
            state_d = ACC;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                ACC: begin
                    if (bus.in_valid) begin
                        acc_d  = sum_ext[ACC_W-1:0];
                        ovf_d  = ovf_q | sum_ext[ACC_W];
                        cnt_en = 1'b1;
                        if (bus.in_last) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = ACC;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        cnt_clr = 1'b1;
                    end
                end
                default: state_d = ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt_o (cnt)
    );

    // in_ready looks only at state and clr, never at in_valid or out_ready.
    assign bus.in_ready  = (state_q == ACC) && !clr;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = acc_q;
    assign bus.out_count = cnt;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed plus randomized bench for prod_accumulator against a whole-frame arithmetic model.
module tb_prod_accumulator;

    import mult_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic clr;

    prod_accumulator_if bus ();

    prod_accumulator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Directed-phase model: running exact total and term count of the open frame.
    longint unsigned m_total;
    int              m_n;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_total = 0;
        m_n     = 0;
    endtask

    // Expected result of a frame from its exact (unbounded) total and length.
    task automatic check_frame(input string tag, input longint unsigned total, input int n);
        longint unsigned mask;
        longint unsigned cmax;
        mask = (64'd1 << ACC_W) - 64'd1;
        cmax = (64'd1 << CNT_W) - 64'd1;
        check({tag, "_valid"}, bus.out_valid, 1'b1);
        check({tag, "_sum"},   bus.out_sum,   total & mask);
        check({tag, "_cnt"},   bus.out_count, (longint'(n) > cmax) ? cmax : longint'(n));
        check({tag, "_ovf"},   bus.out_ovf,   (total >> ACC_W) != 0);
    endtask

    task automatic xfer(input logic [31:0] p, input logic last);
        int waited = 0;
        bus.in_prod  = p;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 50) begin
            tick();
            waited++;
        end
        check("xfer_ready", bus.in_ready, 1'b1);
        tick();
        m_total += longint'(p);
        m_n++;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        tick();
        check("pop_valid", bus.out_valid, 1'b0);
        model_clear();
    endtask

    function automatic int new_len();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return 520;
        if (r < 3)  return 260;
        return $urandom_range(1, 6);
    endfunction

    function automatic logic [31:0] new_prod();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'h0;
        if (r == 1) return 32'hFFFF_FFFF;
        return $urandom;
    endfunction

    task automatic random_phase();
        longint unsigned exp_total[$];
        int              exp_n[$];
        int              frames_started = 1;
        int              frames_done    = 0;
        int              cycles         = 0;
        int              cur_len;
        int              cur_idx        = 0;
        longint unsigned cur_total      = 0;
        int              cur_n          = 0;
        logic            transfer;
        logic            popped;
        cur_len = new_len();
        while (frames_done < 100 && cycles < 40000) begin
            check("rdy_excl", bus.in_ready, !bus.out_valid);
            if (bus.out_valid) begin
                if (exp_total.size() == 0) check("spurious_valid", bus.out_valid, 1'b0);
                else check_frame("rnd", exp_total[0], exp_n[0]);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (frames_started <= 100) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_prod  = new_prod();
                bus.in_last  = bus.in_valid ? (cur_idx == cur_len - 1) : 1'($urandom_range(0, 1));
            end else begin
                bus.in_valid = 1'b0;
                bus.in_last  = 1'($urandom_range(0, 1));
            end
            transfer = bus.in_valid && bus.in_ready;
            popped   = bus.out_valid && bus.out_ready;
            tick();
            cycles++;
            if (transfer) begin
                cur_total += longint'(bus.in_prod);
                cur_n++;
                cur_idx++;
                if (cur_idx == cur_len) begin
                    exp_total.push_back(cur_total);
                    exp_n.push_back(cur_n);
                    frames_started++;
                    cur_len   = new_len();
                    cur_idx   = 0;
                    cur_total = 0;
                    cur_n     = 0;
                end
            end
            if (popped && exp_total.size() != 0) begin
                void'(exp_total.pop_front());
                void'(exp_n.pop_front());
                frames_done++;
            end
        end
        check("rnd_frames_done", frames_done, 100);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [ACC_W-1:0] held_sum;

        rst_n         = 1'b0;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_prod   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        model_clear();

        #12;
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_sum",   bus.out_sum,   0);
        check("rst_cnt",   bus.out_count, 0);
        check("rst_ovf",   bus.out_ovf,   1'b0);
        check("rst_ready", bus.in_ready,  1'b1);
        rst_n = 1'b1;
        tick();

        // Four-term frame, back-to-back, consumer always ready.
        bus.out_ready = 1'b1;
        xfer(32'h0000_0002, 1'b0);
        xfer(32'h0000_03B1, 1'b0);
        xfer(32'hA0B5_D4E5, 1'b0);
        xfer(32'hFFFE_0001, 1'b1);
        check_frame("t1", m_total, m_n);
        tick();
        check("t1_consumed", bus.out_valid, 1'b0);
        model_clear();

        // Single-term frame, then backpressure: result must hold.
        bus.out_ready = 1'b0;
        xfer(32'h0000_03B1, 1'b1);
        check_frame("t2", m_total, m_n);
        held_sum = bus.out_sum;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_sum",   bus.out_sum,   held_sum);
            check("t2_hold_cnt",   bus.out_count, 1);
            check("t2_hold_valid", bus.out_valid, 1'b1);
            check("t2_hold_ready", bus.in_ready,  1'b0);
        end
        pop();

        // Accumulator wrap with sticky overflow, then a fresh frame clears it.
        for (int i = 0; i < 256; i++) xfer(32'hFFFE_0001, 1'b0);
        xfer(32'hFFFE_0001, 1'b1);
        check_frame("t3", m_total, m_n);
        check("t3_sum_lit", bus.out_sum, 40'h00FD_FE01_01);
        pop();
        xfer(32'd5, 1'b1);
        check_frame("t3b", m_total, m_n);
        pop();

        // clr mid-frame refuses the concurrent product and discards the partial sum.
        for (int i = 0; i < 3; i++) xfer(32'h11, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_prod  = 32'h99;
        bus.in_last  = 1'b1;
        clr          = 1'b1;
        #1;
        check("t4_clr_ready", bus.in_ready, 1'b0);
        tick();
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("t4_clr_valid", bus.out_valid, 1'b0);
        check("t4_clr_sum",   bus.out_sum,   0);
        check("t4_clr_cnt",   bus.out_count, 0);
        model_clear();
        xfer(32'd7, 1'b1);
        check_frame("t4", m_total, m_n);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t4_done_clr_valid", bus.out_valid, 1'b0);
        check("t4_done_clr_sum",   bus.out_sum,   0);
        model_clear();

        // Asynchronous reset mid-frame.
        xfer(32'd1, 1'b0);
        xfer(32'd2, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", bus.out_valid, 1'b0);
        check("t5_rst_sum",   bus.out_sum,   0);
        check("t5_rst_cnt",   bus.out_count, 0);
        check("t5_rst_ovf",   bus.out_ovf,   1'b0);
        #2 rst_n = 1'b1;
        model_clear();
        tick();
        xfer(32'h10, 1'b0);
        xfer(32'h20, 1'b1);
        check_frame("t5", m_total, m_n);
        check("t5_sum_lit", bus.out_sum, 40'h30);
        pop();

        random_phase();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
